lsu: RTL and testbench

Load/store unit for the Benzaiten core, sitting directly downstream of `alucon`. For memory instructions it takes the ALU `result` as the effective address, and `rf2` as store data. It runs a single-outstanding request/acknowledge transaction on the data-memory port, and aligns, masks and sign-extends data. It returns a writeback, or a misalignment/illegal fault, to the pipeline control.

---
 rtl/lsu_pkg.sv | 11 +
 rtl/lsu_lane.sv | 25 ++
 rtl/lsu.sv | 104 ++++++++++
 tb/tb_lsu.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the Benzaiten load/store unit.
package lsu_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;
   typedef enum logic [1:0] {MEM_B = 2'b00, MEM_H = 2'b01, MEM_W = 2'b10} memsize_t;
   typedef enum logic [1:0] {FAULT_NONE = 2'b00, FAULT_MISALIGN = 2'b01, FAULT_ILLEGAL = 2'b10} lsu_fault_t;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   function automatic memsize_t f3_size(input logic [2:0] f3);
      return memsize_t'(f3[1:0]);
   endfunction
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: byte-lane strobes, store data shifting and load extraction/extension.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] sdata,
   output logic [31:0] ldata
);
   memsize_t    sz;
   logic [31:0] r;
   always_comb begin
      sz    = f3_size(funct3);
      r     = rdata >> {off, 3'b000};
      wstrb = sz == MEM_W ? 4'b1111 : (sz == MEM_H ? 4'b0011 : 4'b0001) << off;
      sdata = wdata << {off, 3'b000};
      // funct3[2] selects the unsigned (LBU/LHU) variants
      ldata = sz == MEM_W ? r :
              sz == MEM_H ? {{16{r[15] & ~funct3[2]}}, r[15:0]} :
                            {{24{r[7] & ~funct3[2]}}, r[7:0]};
   end
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit with alignment, masking and fault detection.
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [4:0]        rd,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              done,
   output logic              wb_we,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic              fault,
   output logic [1:0]        fault_cause
);
   lsu_state_t  state;
   logic [2:0]  f3;
   logic [1:0]  off;
   logic        idle, illegal, misal;
   logic [3:0]  strb;
   logic [31:0] sdata, ldata;
   assign idle      = state == IDLE;
   assign req_ready = idle;
   assign illegal   = is_store ? funct3[2] | (&funct3[1:0]) : (&funct3[1:0]) | (funct3 == 3'b110);
   assign misal     = (f3_size(funct3) == MEM_H & addr[0]) | (f3_size(funct3) == MEM_W & |addr[1:0]);
   // in IDLE the lane sees the incoming request; afterwards the latched one
   lsu_lane u_lane (
      .funct3(idle ? funct3 : f3),
      .off   (idle ? addr[1:0] : off),
      .wdata (wdata),
      .rdata (mem_rdata),
      .wstrb (strb),
      .sdata (sdata),
      .ldata (ldata)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         f3          <= '0;
         off         <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wstrb   <= '0;
         mem_wdata   <= '0;
         done        <= 1'b0;
         wb_we       <= 1'b0;
         wb_rd       <= '0;
         wb_data     <= '0;
         fault       <= 1'b0;
         fault_cause <= FAULT_NONE;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               f3        <= funct3;
               off       <= addr[1:0];
               wb_rd     <= rd;
               mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
               mem_we    <= is_store;
               mem_wstrb <= is_store ? strb : 4'b0000;
               mem_wdata <= sdata;
               if (illegal | misal) begin
                  state       <= RESP;
                  done        <= 1'b1;
                  fault       <= 1'b1;
                  fault_cause <= illegal ? FAULT_ILLEGAL : FAULT_MISALIGN;
               end else begin
                  state   <= ACCESS;
                  mem_req <= 1'b1;
               end
            end
            ACCESS: if (mem_ack) begin
               state   <= RESP;
               mem_req <= 1'b0;
               done    <= 1'b1;
               wb_we   <= ~mem_we & (wb_rd != 5'd0);
               if (!mem_we) wb_data <= ldata;
            end
            RESP: begin
               state       <= IDLE;
               done        <= 1'b0;
               wb_we       <= 1'b0;
               fault       <= 1'b0;
               fault_cause <= FAULT_NONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu against a behavioural model.
module tb_lsu;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, is_store = 1'b0, mem_ack = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
   logic [4:0]  rd = '0;
   logic        req_ready, mem_req, mem_we, done, wb_we, fault;
   logic [31:0] mem_addr, mem_wdata, wb_data;
   logic [3:0]  mem_wstrb;
   logic [4:0]  wb_rd;
   logic [1:0]  fault_cause;

   lsu #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata), .rd(rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .done(done),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault), .fault_cause(fault_cause)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0, ndone = 0, last_k = 0;
   logic        e_st = 1'b0;
   logic [2:0]  e_f3 = '0;
   logic [31:0] e_addr = '0, e_wd = '0;
   logic [4:0]  e_rd = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] m_cause(input logic st, input logic [2:0] f3, input logic [31:0] a);
      logic ill, mis;
      ill = st ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      mis = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
      return ill ? 2'b10 : mis ? 2'b01 : 2'b00;
   endfunction

   function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
      int o = int'(a[1:0]);
      case (f3[1:0])
         2'd0:    return 4'(1 << o);
         2'd1:    return 4'(3 << o);
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input logic [31:0] a, input logic [31:0] wd);
      return wd << (8 * int'(a[1:0]));
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      logic [7:0] b[4];
      int o = int'(a[1:0]);
      for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
      case (f3)
         3'd0:    return {{24{b[o][7]}}, b[o]};
         3'd4:    return {24'h0, b[o]};
         3'd1:    return {{16{b[o|1][7]}}, b[o|1], b[o]};
         3'd5:    return {16'h0, b[o|1], b[o]};
         default: return w;
      endcase
   endfunction

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (mem_req) begin
            chk("mem_addr", mem_addr, e_addr & ~32'd3);
            chk("mem_we", mem_we, e_st);
            chk("mem_wstrb", mem_wstrb, e_st ? m_strb(e_f3, e_addr) : 4'h0);
            if (e_st) chk("mem_wdata", mem_wdata, m_wdata(e_addr, e_wd));
            chk("req_on_fault", m_cause(e_st, e_f3, e_addr), 2'b00);
         end
         if (done) begin
            ndone++;
            chk("fault", fault, m_cause(e_st, e_f3, e_addr) != 2'b00);
            chk("fault_cause", fault_cause, m_cause(e_st, e_f3, e_addr));
            chk("wb_we", wb_we, !e_st && m_cause(e_st, e_f3, e_addr) == 2'b00 && e_rd != 5'd0);
            if (!e_st && m_cause(e_st, e_f3, e_addr) == 2'b00)
               chk("wb_data", wb_data, m_load(e_f3, e_addr, mem_rdata));
            if (wb_we) chk("wb_rd", wb_rd, e_rd);
         end
      end
   end

   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] r, input logic [31:0] rdv, input int waits);
      int n0, k;
      e_st = st; e_f3 = f3; e_addr = a; e_wd = wd; e_rd = r; mem_rdata = rdv;
      k = 0;
      while (!req_ready && k < 20) begin @(negedge clk); #1; k++; end
      chk("ready_timeout", req_ready, 1'b1);
      last_k = k;
      n0 = ndone;
      req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; rd = r;
      @(posedge clk); #1 req_valid = 1'b0;
      if (m_cause(st, f3, a) != 2'b00) begin
         @(negedge clk);
         chk("flt_done", done, 1'b1);
         chk("flt_noreq", mem_req, 1'b0);
         chk("flt_busy", req_ready, 1'b0);
         #1 @(negedge clk);
         chk("flt_ready", req_ready, 1'b1);
         chk("flt_noreq2", mem_req, 1'b0);
         #1;
      end else begin
         for (int w = 0; w <= waits; w++) begin
            @(negedge clk);
            chk("mem_req_hold", mem_req, 1'b1);
            chk("early_done", done, 1'b0);
            #1 mem_ack = (w == waits);
         end
         @(posedge clk); #1 mem_ack = 1'b0;
         @(negedge clk);
         chk("done", done, 1'b1);
         chk("busy_in_resp", req_ready, 1'b0);
         chk("req_dropped", mem_req, 1'b0);
         #1;
      end
      chk("done_count", ndone - n0, 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_outs", {mem_req, mem_we, done, wb_we, fault, mem_wstrb, fault_cause}, '0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_wb", {wb_rd, wb_data}, '0);
      #1;
      chk("pin_lb", m_load(3'd0, 32'h1003, 32'h80123456), 32'hFFFFFF80);
      chk("pin_lbu", m_load(3'd4, 32'h1003, 32'h80123456), 32'h00000080);
      chk("pin_lh", m_load(3'd1, 32'h4002, 32'h80010000), 32'hFFFF8001);
      chk("pin_sh_strb", m_strb(3'd1, 32'h2002), 4'b1100);
      chk("pin_sh_data", m_wdata(32'h2002, 32'h1234ABCD), 32'hABCD0000);
      chk("pin_misal", m_cause(1'b0, 3'd2, 32'h3001), 2'b01);
      chk("pin_illegal", m_cause(1'b0, 3'd3, 32'h3000), 2'b10);

      issue(1'b0, 3'd0, 32'h1003, 32'h0, 5'd5, 32'h80123456, 0);
      issue(1'b0, 3'd4, 32'h1003, 32'h0, 5'd5, 32'h80123456, 0);
      chk("b2b_gap_zero_wait", last_k, 1);
      issue(1'b1, 3'd1, 32'h2002, 32'h1234ABCD, 5'd3, 32'h0, 0);
      issue(1'b1, 3'd0, 32'h2001, 32'h000000A5, 5'd0, 32'h0, 1);
      issue(1'b0, 3'd2, 32'h3001, 32'h0, 5'd7, 32'h0, 0);
      issue(1'b0, 3'd3, 32'h3000, 32'h0, 5'd7, 32'h0, 0);
      chk("gap_after_fault", last_k, 0);
      issue(1'b1, 3'd3, 32'h3000, 32'h0, 5'd7, 32'h0, 0);
      issue(1'b1, 3'd1, 32'h3003, 32'h0, 5'd7, 32'h0, 0);
      issue(1'b0, 3'd5, 32'h3001, 32'h0, 5'd7, 32'h0, 0);
      issue(1'b0, 3'd2, 32'h4000, 32'h0, 5'd0, 32'hDEADBEEF, 2);
      issue(1'b0, 3'd1, 32'h4002, 32'h0, 5'd4, 32'h80010000, 0);
      chk("b2b_gap_waited", last_k, 1);
      issue(1'b0, 3'd5, 32'h4002, 32'h0, 5'd4, 32'h80010000, 0);

      begin
         int n0;
         e_st = 1'b1; e_f3 = 3'd2; e_addr = 32'h5000; e_wd = 32'h11223344; e_rd = 5'd0;
         while (!req_ready) begin @(negedge clk); #1; end
         n0 = ndone;
         req_valid = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 32'h5000; wdata = 32'h11223344; rd = 5'd0;
         @(posedge clk); #1 req_valid = 1'b0;
         @(negedge clk);
         chk("abort_req1", mem_req, 1'b1);
         @(posedge clk); #1 rst = 1'b1;
         @(posedge clk); #1 rst = 1'b0;
         @(negedge clk);
         chk("abort_req_drop", mem_req, 1'b0);
         chk("abort_ready", req_ready, 1'b1);
         repeat (3) @(negedge clk);
         chk("abort_no_done", ndone - n0, 0);
         #1 mem_ack = 1'b1;
         @(posedge clk); #1 mem_ack = 1'b0;
         @(negedge clk);
         chk("stray_ack", {done, mem_req, req_ready}, 3'b001);
         #1;
      end
      issue(1'b0, 3'd2, 32'h6004, 32'h0, 5'd9, 32'hCAFEF00D, 1);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end
endmodule
